// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : MIPS EX stage: ID/EX register, operand forwarding, dest select, ALU
// Revision : 1.0
// ============================================================================
module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        FlushE,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        MemWriteD,
    input  logic [3:0]  ALUControlD,
    input  logic        ALUSrcD,
    input  logic        RegDstD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    input  logic [31:0] SignImmD,
    input  logic [4:0]  shamtD,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic        MemWriteE,
    output logic        RegDstE,
    output logic [3:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic [31:0] SignImmE,
    input  logic [31:0] ResultW,
    input  logic [31:0] ALUOutM,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    output logic [4:0]  WriteRegE,
    output logic [31:0] WriteDataE,
    output logic [31:0] ALUOutE
);

    localparam logic [3:0] c_ALU_AND = 4'd0;
    localparam logic [3:0] c_ALU_OR  = 4'd1;
    localparam logic [3:0] c_ALU_ADD = 4'd2;
    localparam logic [3:0] c_ALU_XOR = 4'd3;
    localparam logic [3:0] c_ALU_SLL = 4'd4;
    localparam logic [3:0] c_ALU_SRL = 4'd5;
    localparam logic [3:0] c_ALU_SUB = 4'd6;
    localparam logic [3:0] c_ALU_SLT = 4'd7;
    localparam logic [3:0] c_ALU_SRA = 4'd8;
    localparam logic [3:0] c_ALU_NOR = 4'd12;

    logic        r_aluSrcE;
    logic [4:0]  r_shamtE;
    logic [31:0] w_srcAE;
    logic [31:0] w_srcBE;

    // A flush loads an all-zero bubble: no write, no store, destination $0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= 4'd0;
            r_aluSrcE   <= 1'b0;
            RD1E        <= 32'd0;
            RD2E        <= 32'd0;
            RsE         <= 5'd0;
            RtE         <= 5'd0;
            RdE         <= 5'd0;
            SignImmE    <= 32'd0;
            r_shamtE    <= 5'd0;
        end else if (FlushE) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= 4'd0;
            r_aluSrcE   <= 1'b0;
            RD1E        <= 32'd0;
            RD2E        <= 32'd0;
            RsE         <= 5'd0;
            RtE         <= 5'd0;
            RdE         <= 5'd0;
            SignImmE    <= 32'd0;
            r_shamtE    <= 5'd0;
        end else begin
            RegWriteE   <= RegWriteD;
            MemtoRegE   <= MemtoRegD;
            MemWriteE   <= MemWriteD;
            RegDstE     <= RegDstD;
            ALUControlE <= ALUControlD;
            r_aluSrcE   <= ALUSrcD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= RdD;
            SignImmE    <= SignImmD;
            r_shamtE    <= shamtD;
        end
    end

    assign WriteRegE = RegDstE ? RdE : RtE;

    always_comb begin
        w_srcAE = 32'd0;
        case (ForwardAE)
            2'd0:    w_srcAE = RD1E;
            2'd1:    w_srcAE = ResultW;
            2'd2:    w_srcAE = ALUOutM;
            default: w_srcAE = 32'd0;
        endcase
    end

    always_comb begin
        WriteDataE = 32'd0;
        case (ForwardBE)
            2'd0:    WriteDataE = RD2E;
            2'd1:    WriteDataE = ResultW;
            2'd2:    WriteDataE = ALUOutM;
            default: WriteDataE = 32'd0;
        endcase
    end

    assign w_srcBE = r_aluSrcE ? SignImmE : WriteDataE;

    // Shifts take their value from operand B and their amount from shamt.
    always_comb begin
        ALUOutE = 32'd0;
        case (ALUControlE)
            c_ALU_AND: ALUOutE = w_srcAE & w_srcBE;
            c_ALU_OR:  ALUOutE = w_srcAE | w_srcBE;
            c_ALU_ADD: ALUOutE = w_srcAE + w_srcBE;
            c_ALU_XOR: ALUOutE = w_srcAE ^ w_srcBE;
            c_ALU_SLL: ALUOutE = w_srcBE << r_shamtE;
            c_ALU_SRL: ALUOutE = w_srcBE >> r_shamtE;
            c_ALU_SUB: ALUOutE = w_srcAE - w_srcBE;
            c_ALU_SLT: ALUOutE = {31'd0, ($signed(w_srcAE) < $signed(w_srcBE))};
            c_ALU_SRA: ALUOutE = $signed(w_srcBE) >>> r_shamtE;
            c_ALU_NOR: ALUOutE = ~(w_srcAE | w_srcBE);
            default:   ALUOutE = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Scoreboard bench for execute_stage against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        FlushE;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [3:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, SignImmD;
    logic [4:0]  RsD, RtD, RdD, shamtD;
    logic        RegWriteE, MemtoRegE, MemWriteE, RegDstE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [4:0]  RsE, RtE, RdE;
    logic [31:0] ResultW, ALUOutM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [4:0]  WriteRegE;
    logic [31:0] WriteDataE, ALUOutE;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .SignImmD(SignImmD), .shamtD(shamtD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .RegDstE(RegDstE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
        .ResultW(ResultW), .ALUOutM(ALUOutM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .WriteRegE(WriteRegE), .WriteDataE(WriteDataE), .ALUOutE(ALUOutE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regWrite, memtoReg, memWrite, regDst, aluSrc;
        logic [3:0]  aluCtl;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd, shamt;
    } latch_t;

    typedef struct {
        latch_t      l;
        logic [4:0]  writeReg;
        logic [31:0] writeData, aluOut;
    } exp_t;

    latch_t model;
    exp_t   sbq[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares whatever the stage is presenting against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("RegWriteE",   {31'd0, RegWriteE}, {31'd0, e.l.regWrite});
                check("MemtoRegE",   {31'd0, MemtoRegE}, {31'd0, e.l.memtoReg});
                check("MemWriteE",   {31'd0, MemWriteE}, {31'd0, e.l.memWrite});
                check("RegDstE",     {31'd0, RegDstE},   {31'd0, e.l.regDst});
                check("ALUControlE", {28'd0, ALUControlE}, {28'd0, e.l.aluCtl});
                check("RD1E",        RD1E, e.l.rd1);
                check("RD2E",        RD2E, e.l.rd2);
                check("RsE",         {27'd0, RsE}, {27'd0, e.l.rs});
                check("RtE",         {27'd0, RtE}, {27'd0, e.l.rt});
                check("RdE",         {27'd0, RdE}, {27'd0, e.l.rd});
                check("SignImmE",    SignImmE, e.l.imm);
                check("WriteRegE",   {27'd0, WriteRegE}, {27'd0, e.writeReg});
                check("WriteDataE",  WriteDataE, e.writeData);
                check("ALUOutE",     ALUOutE, e.aluOut);
            end
        end
    end

    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        longint sa, sb;
        logic [31:0] fill;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd3:  return a ^ b;
            4'd4:  return 32'((64'(b) * (64'd1 << sh)) % 64'h1_0000_0000);
            4'd5:  return 32'(64'(b) / (64'd1 << sh));
            4'd6:  return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return 32'(64'(b) / (64'd1 << sh)) | fill;
            4'd12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t predict(input latch_t l, input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [31:0] resW, input logic [31:0] aluM);
        exp_t e;
        logic [31:0] srcs[4];
        logic [31:0] a, b;
        srcs[0] = l.rd1; srcs[1] = resW; srcs[2] = aluM; srcs[3] = 32'd0;
        a = srcs[fa];
        srcs[0] = l.rd2;
        e.l = l;
        e.writeData = srcs[fb];
        b = l.aluSrc ? l.imm : e.writeData;
        e.writeReg = l.regDst ? l.rd : l.rt;
        e.aluOut = aluRef(l.aluCtl, a, b, l.shamt);
        return e;
    endfunction

    function automatic latch_t zeroLatch();
        latch_t z;
        z = '{regWrite:0, memtoReg:0, memWrite:0, regDst:0, aluSrc:0, aluCtl:0,
              rd1:0, rd2:0, imm:0, rs:0, rt:0, rd:0, shamt:0};
        return z;
    endfunction

    // One clock: the model captures the D inputs (or a bubble), then forwarding is applied.
    task automatic step(input logic flush, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] resW, input logic [31:0] aluM, input bit push);
        FlushE = flush;
        @(posedge clk);
        if (flush) model = zeroLatch();
        else model = '{regWrite:RegWriteD, memtoReg:MemtoRegD, memWrite:MemWriteD,
                       regDst:RegDstD, aluSrc:ALUSrcD, aluCtl:ALUControlD,
                       rd1:RD1D, rd2:RD2D, imm:SignImmD, rs:RsD, rt:RtD, rd:RdD,
                       shamt:shamtD};
        #1;
        FlushE = 1'b0;
        ForwardAE = fa; ForwardBE = fb; ResultW = resW; ALUOutM = aluM;
        if (push) sbq.push_back(predict(model, fa, fb, resW, aluM));
    endtask

    task automatic randomD();
        RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom); MemWriteD = 1'($urandom);
        ALUSrcD = 1'($urandom); RegDstD = 1'($urandom); ALUControlD = 4'($urandom);
        RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
        RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom); shamtD = 5'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; FlushE = 1'b0;
        RegWriteD = 1; MemtoRegD = 1; MemWriteD = 1; ALUSrcD = 0; RegDstD = 0;
        ALUControlD = 4'd2; RD1D = 0; RD2D = 0; SignImmD = 0;
        RsD = 5'd1; RtD = 5'd12; RdD = 5'd16; shamtD = 0;
        ResultW = 0; ALUOutM = 0; ForwardAE = 0; ForwardBE = 0;
        model = zeroLatch();
        #1 sbq.push_back(predict(model, 2'd0, 2'd0, 32'd0, 32'd0));
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Destination select and flush
        step(0, 0, 0, 0, 0, 1);
        RegDstD = 1;
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);

        // Store-data forwarding
        RegDstD = 0; RD2D = 3; RD1D = 42; ALUControlD = 4'd0;
        step(0, 0, 0, 32, 22, 1);
        step(0, 0, 1, 32, 22, 1);
        step(0, 0, 2, 32, 22, 1);

        // ALU with forwarding
        step(0, 0, 0, 32, 22, 1);
        ALUControlD = 4'd1; step(0, 1, 0, 32, 22, 1);
        ALUControlD = 4'd2; step(0, 0, 1, 32, 22, 1);
        ALUControlD = 4'd6; step(0, 2, 1, 32, 22, 1);

        // SLT against immediate
        ALUControlD = 4'd7; ALUSrcD = 1; SignImmD = 0;
        step(0, 2, 0, 32, 22, 1);
        SignImmD = 32'hFFFF_FFFF; step(0, 2, 0, 32, 22, 1);
        SignImmD = 32'd1; step(0, 1, 0, 32'hFFFF_FFFE, 22, 1);

        // Shifts
        ALUSrcD = 0; RD2D = 32'h8000_0000; shamtD = 5'd4;
        ALUControlD = 4'd4; step(0, 0, 0, 0, 0, 1);
        ALUControlD = 4'd5; step(0, 0, 0, 0, 0, 1);
        ALUControlD = 4'd8; step(0, 0, 0, 0, 0, 1);

        // Asynchronous reset between edges, then normal load on release
        randomD();
        step(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        model = zeroLatch();
        #1 sbq.push_back(predict(model, 2'd0, 2'd0, 32'd0, 32'd0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        randomD();
        step(0, 0, 0, 0, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            randomD();
            step(($urandom_range(0, 9) == 0), 2'($urandom), 2'($urandom),
                 $urandom, $urandom, 1);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Execute (EX) stage of the 5-stage pipelined MIPS core. It holds the ID/EX pipeline register for decoded control, operands, register numbers and immediate. It applies the hazard unit's forwarding selects, chooses the destination register and evaluates the ALU. Its outputs feed the EX/MEM register and the hazard unit.

Parameters:
None; all widths are fixed: 32-bit datapath, 5-bit register numbers, 4-bit ALU control.

Ports:
clk  in  1  pipeline clock, rising edge active
rst_n  in  1  asynchronous active-low reset
FlushE  in  1  synchronous flush of the ID/EX register (bubble insert)
RegWriteD  in  1  decode-stage register-write enable
MemtoRegD  in  1  decode-stage load-result select
MemWriteD  in  1  decode-stage memory-write enable
ALUControlD  in  4  decode-stage ALU operation
ALUSrcD  in  1  1 = ALU operand B is the immediate
RegDstD  in  1  1 = destination is rd, 0 = rt
RD1D  in  32  register file read data 1
RD2D  in  32  register file read data 2
RsD  in  5  rs field
RtD  in  5  rt field
RdD  in  5  rd field
SignImmD  in  32  sign-extended immediate
shamtD  in  5  shift amount
RegWriteE  out  1  registered RegWriteD
MemtoRegE  out  1  registered MemtoRegD
MemWriteE  out  1  registered MemWriteD
RegDstE  out  1  registered RegDstD
ALUControlE  out  4  registered ALUControlD
RD1E  out  32  registered RD1D
RD2E  out  32  registered RD2D
RsE  out  5  registered RsD
RtE  out  5  registered RtD
RdE  out  5  registered RdD
SignImmE  out  32  registered SignImmD
ResultW  in  32  writeback-stage result (forward source)
ALUOutM  in  32  memory-stage ALU result (forward source)
ForwardAE  in  2  operand A forward select
ForwardBE  in  2  operand B forward select
WriteRegE  out  5  destination register number
WriteDataE  out  32  forwarded store data / pre-immediate operand B
ALUOutE  out  32  ALU result

Behaviour:
- ID/EX register: every *D input, including ALUSrcD and shamtD (internal ALUSrcE, shamtE), captured on rising clk; one-cycle latency.
- rst_n low: all registered fields cleared to 0 immediately, asynchronously. Reset has priority over FlushE.
- FlushE high at a rising edge: all registered fields load 0 instead of the D inputs; the stage then carries a NOP (no write, no store, WriteRegE = 0).
- WriteRegE = RegDstE ? RdE : RtE; combinational.
- SrcAE by ForwardAE: 0 -> RD1E, 1 -> ResultW, 2 -> ALUOutM, 3 -> 0.
- WriteDataE by ForwardBE: 0 -> RD2E, 1 -> ResultW, 2 -> ALUOutM, 3 -> 0.
- SrcBE = ALUSrcE ? SignImmE : WriteDataE.
- Forward selects, ResultW and ALUOutM are used combinationally in the current cycle; they are not registered.
- ALU operations, selected by ALUControlE, 32-bit, carry/overflow discarded:
  - 0 AND; 1 OR; 2 ADD; 3 XOR; 4 SLL (SrcBE << shamtE); 5 SRL (SrcBE >> shamtE); 6 SUB (SrcAE - SrcBE)
  - 7 SLT: 1 if signed SrcAE < signed SrcBE, else 0
  - 8 SRA (SrcBE >>> shamtE, arithmetic); 12 NOR
  - any other code -> 0
- ALUOutE is purely combinational from the E registers and the forwarding inputs.

Test Plan:
- Destination select: RtD=12, RdD=16, RegDstD=0, clock -> WriteRegE=12; RegDstD=1, clock -> WriteRegE=16; FlushE=1, clock -> WriteRegE=0 and all *E outputs 0.
- Store-data forwarding: RD2E=3, ResultW=32, ALUOutM=22. ForwardBE 0 -> WriteDataE=3; 1 -> 32; 2 -> 22.
- ALU with forwarding: RD1E=42, RD2E=3, ALUSrcE=0.
  - AND, FwdA=0, FwdB=0 -> 2
  - OR, FwdA=1 (ResultW=32) -> 35
  - ADD, FwdB=1 -> 74
  - SUB, FwdA=2, FwdB=1 -> 22-32 = 0xFFFFFFF6
- SLT with immediate: ALUSrcD=1, SignImmD=0, FwdA=2 (ALUOutM=22) -> 0. SignImmD=0xFFFFFFFF with SrcA=22 -> 0 (signed). SrcA=0xFFFFFFFE vs imm 1 -> 1.
- Shifts: SrcB=0x80000000, shamt=4 -> SLL 0, SRL 0x08000000, SRA 0xF8000000.
- Reset: assert rst_n=0 between clock edges -> all *E outputs and WriteRegE go 0 immediately. Hold FlushE=0 on release -> next edge loads inputs normally.
